// File: rtl/mul_div_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_if
//  Brief    : Request/response bundle between the EX-stage issuer and the
//             iterative RV32M multiply/divide unit.
//  Revision : 1.0
// ============================================================================
interface mul_div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      aluop;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    // Issuer side (pipeline / hazard logic)
    modport master (
        output start, aluop, data1, data2, kill,
        input  busy, done, result
    );

    // Unit side
    modport slave (
        input  start, aluop, data1, data2, kill,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Brief    : Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply
//             and restoring divide, one iteration per clock over XLEN cycles.
//             Divide-by-zero and signed overflow complete in a single cycle.
//  Revision : 1.0
// ============================================================================
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mul_div_if.slave     bus
);
    localparam int c_CW = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);

    localparam logic [4:0] c_OP_MUL    = 5'b01011;
    localparam logic [4:0] c_OP_MULH   = 5'b01100;
    localparam logic [4:0] c_OP_MULHSU = 5'b01101;
    localparam logic [4:0] c_OP_MULHU  = 5'b01110;
    localparam logic [4:0] c_OP_DIV    = 5'b01111;
    localparam logic [4:0] c_OP_DIVU   = 5'b10000;
    localparam logic [4:0] c_OP_REM    = 5'b10001;
    localparam logic [4:0] c_OP_REMU   = 5'b10010;

    localparam logic [XLEN-1:0] c_MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_count;
    logic [4:0]        r_op;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;     // multiply: {partial high, remaining multiplier}
    logic [XLEN-1:0]   r_opa;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   r_quo;     // dividend bits shifting out, quotient bits shifting in
    logic [XLEN:0]     r_rem;     // partial remainder
    logic [XLEN-1:0]   r_result;

    logic              w_is_m;
    logic              w_is_div;
    logic              w_is_rem;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sign1;
    logic              w_sign2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_neg_in;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;

    // Decode the incoming request: operand signedness, magnitudes, result sign, special cases
    always_comb begin
        w_is_m        = (bus.aluop >= c_OP_MUL) && (bus.aluop <= c_OP_REMU);
        w_is_div      = (bus.aluop >= c_OP_DIV);
        w_is_rem      = (bus.aluop == c_OP_REM) || (bus.aluop == c_OP_REMU);
        w_a_signed    = (bus.aluop == c_OP_MUL) || (bus.aluop == c_OP_MULH) ||
                        (bus.aluop == c_OP_MULHSU) || (bus.aluop == c_OP_DIV) ||
                        (bus.aluop == c_OP_REM);
        w_b_signed    = (bus.aluop == c_OP_MUL) || (bus.aluop == c_OP_MULH) ||
                        (bus.aluop == c_OP_DIV) || (bus.aluop == c_OP_REM);
        w_sign1       = w_a_signed & bus.data1[XLEN-1];
        w_sign2       = w_b_signed & bus.data2[XLEN-1];
        w_mag1        = w_sign1 ? -bus.data1 : bus.data1;
        w_mag2        = w_sign2 ? -bus.data2 : bus.data2;
        // Remainder follows the dividend; everything else is sign1 ^ sign2
        w_neg_in      = w_is_rem ? w_sign1 : (w_sign1 ^ w_sign2);
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_is_div && (bus.data2 == '0)) begin
            w_special     = 1'b1;
            w_special_res = w_is_rem ? bus.data1 : '1;
        end else if (((bus.aluop == c_OP_DIV) || (bus.aluop == c_OP_REM)) &&
                     (bus.data1 == c_MIN_INT) && (bus.data2 == '1)) begin
            w_special     = 1'b1;
            w_special_res = w_is_rem ? '0 : c_MIN_INT;
        end
    end

    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic              w_ge;
    logic [XLEN:0]     w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_final;

    // One multiply and one divide iteration, plus sign-corrected final result
    always_comb begin
        w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
        w_acc_nxt  = {w_sum, r_acc[XLEN-1:1]};
        w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
        w_diff     = {1'b0, w_shift} - {2'b00, r_opa};
        w_ge       = ~w_diff[XLEN+1];
        w_rem_nxt  = w_ge ? w_diff[XLEN:0] : w_shift;
        w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
        w_prod_fix = r_neg ? -w_acc_nxt : w_acc_nxt;
        case (r_op)
            c_OP_MUL:                        w_final = w_prod_fix[XLEN-1:0];
            c_OP_MULH, c_OP_MULHSU,
            c_OP_MULHU:                      w_final = w_prod_fix[2*XLEN-1:XLEN];
            c_OP_DIV, c_OP_DIVU:             w_final = r_neg ? -w_quo_nxt : w_quo_nxt;
            default:                         w_final = r_neg ? -w_rem_nxt[XLEN-1:0]
                                                             : w_rem_nxt[XLEN-1:0];
        endcase
    end

    // Control FSM and datapath registers; KILL overrides acceptance and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
        end else if (bus.kill) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && w_is_m) begin
                        r_op    <= bus.aluop;
                        r_neg   <= w_neg_in;
                        r_count <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_FIN;
                        end else begin
                            r_opa   <= w_is_div ? w_mag2 : w_mag1;
                            r_acc   <= {{XLEN{1'b0}}, w_mag2};
                            r_quo   <= w_mag1;
                            r_rem   <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_op >= c_OP_DIV) begin
                        r_quo <= w_quo_nxt;
                        r_rem <= w_rem_nxt;
                    end else begin
                        r_acc <= w_acc_nxt;
                    end
                    if (r_count == c_LAST) begin
                        r_result <= w_final;
                        r_count  <= '0;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_FIN);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Brief    : Self-checking bench for mul_div_unit: directed RV32M cases,
//             randomized operations against an arithmetic reference model,
//             KILL / async reset / ignored-request scenarios.
//  Revision : 1.0
// ============================================================================
module tb_mul_div_unit;
    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [31:0] last_result;

    mul_div_if #(.XLEN(32)) bus_if ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything escapes the bounded waits
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, sp;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            OP_MULH:   begin sp = sa * sb; p = sp; return p[63:32]; end
            OP_MULHSU: begin sp = sa * longint'({32'b0, b}); p = sp; return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                sp = sa / sb; p = sp; return p[31:0];
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sp = sa % sb; p = sp; return p[31:0];
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'h0;
        endcase
    endfunction

    // Issue one operation (called at a negedge with the unit idle) and check
    // latency, busy duration, result, single-cycle DONE and FIN-cycle START rejection.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        bit          special;
        bit          seen;
        int          busy_cnt;
        int          idx;
        exp     = ref_model(op, a, b);
        special = (op >= OP_DIV) && ((b == 0) ||
                  (((op == OP_DIV) || (op == OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        bus_if.start = 1'b1;
        bus_if.aluop = op;
        bus_if.data1 = a;
        bus_if.data2 = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.data1 = $urandom;
        bus_if.data2 = $urandom;
        busy_cnt = 0;
        idx      = 0;
        seen     = 1'b0;
        while (idx < 40 && !seen) begin
            if (bus_if.done) begin
                seen = 1'b1;
            end else begin
                if (bus_if.busy) busy_cnt++;
                if (idx == 5) begin
                    bus_if.start = 1'b1;
                    bus_if.aluop = OP_MUL;
                end else begin
                    bus_if.start = 1'b0;
                end
                @(negedge clk);
                idx++;
            end
        end
        bus_if.start = 1'b0;
        check($sformatf("done_latency op=%b", op), 32'(idx), special ? 32'd0 : 32'd32);
        check($sformatf("busy_cycles op=%b", op), 32'(busy_cnt), special ? 32'd0 : 32'd32);
        check($sformatf("result op=%b a=%h b=%h", op, a, b), bus_if.result, exp);
        last_result = exp;
        // START presented in the FIN cycle must be ignored
        bus_if.start = 1'b1;
        bus_if.aluop = op;
        bus_if.data1 = a;
        bus_if.data2 = b;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("done_one_cycle", {31'b0, bus_if.done}, 32'd0);
        check("fin_start_ignored", {31'b0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        int          dcount;
        n_cmp  = 0;
        n_fail = 0;
        last_result = '0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.aluop = '0;
        bus_if.data1 = '0;
        bus_if.data2 = '0;
        bus_if.kill  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, bus_if.busy}, 32'd0);
        check("reset_done",   {31'b0, bus_if.done}, 32'd0);
        check("reset_result", bus_if.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, issued back-to-back
        do_op(OP_MUL,    32'd7,          32'hFFFF_FFFD);
        do_op(OP_MULH,   32'h8000_0000,  32'h8000_0000);
        do_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        do_op(OP_DIV,    32'hFFFF_FFF9,  32'd2);
        do_op(OP_REM,    32'hFFFF_FFF9,  32'd2);
        do_op(OP_DIVU,   32'd100,        32'd7);
        do_op(OP_REMU,   32'd100,        32'd7);
        do_op(OP_DIVU,   32'h1234_5678,  32'd0);
        do_op(OP_REM,    32'd5,          32'd0);
        do_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF);
        do_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF);
        do_op(OP_DIV,    32'd9,          32'd0);
        do_op(OP_REMU,   32'hDEAD_BEEF,  32'd0);

        // Non-M ALU op must be ignored
        bus_if.start = 1'b1;
        bus_if.aluop = 5'b00001;
        bus_if.data1 = 32'd3;
        bus_if.data2 = 32'd4;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("add_ignored_busy", {31'b0, bus_if.busy}, 32'd0);
        check("add_ignored_done", {31'b0, bus_if.done}, 32'd0);
        @(negedge clk);
        check("add_ignored_done2", {31'b0, bus_if.done}, 32'd0);

        // KILL at count 10: back to IDLE, no DONE, result unchanged
        bus_if.start = 1'b1;
        bus_if.aluop = OP_MUL;
        bus_if.data1 = 32'd123;
        bus_if.data2 = 32'd456;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);
        check("kill_pre_busy", {31'b0, bus_if.busy}, 32'd1);
        bus_if.kill = 1'b1;
        @(negedge clk);
        bus_if.kill = 1'b0;
        check("kill_busy", {31'b0, bus_if.busy}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.done) dcount++;
            @(negedge clk);
        end
        check("kill_no_done", 32'(dcount), 32'd0);
        check("kill_result_held", bus_if.result, last_result);

        // Unit usable after KILL
        do_op(OP_DIVU, 32'd1000, 32'd33);

        // Asynchronous reset mid-run clears outputs immediately
        bus_if.start = 1'b1;
        bus_if.aluop = OP_DIVU;
        bus_if.data1 = 32'd77;
        bus_if.data2 = 32'd5;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy",   {31'b0, bus_if.busy}, 32'd0);
        check("arst_done",   {31'b0, bus_if.done}, 32'd0);
        check("arst_result", bus_if.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized operations against the reference model
        for (int n = 0; n < 60; n++) begin
            rop = 5'(32'd11 + $urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2:       rb = 32'($urandom_range(1, 15));
                3:       begin ra = 32'($urandom_range(0, 255)); rb = $urandom; end
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
